rs_alu_station: RTL
===================

# rs_alu_station

Reservation station for the add/sub functional unit, directly downstream of the issue stage. It accepts issued instructions tagged with their ROB index and holds them until both source operands are available. It snoops the common data bus (CDB) to wake up waiting operands and dispatches the oldest ready entry to the ALU through a valid/ready handshake. Its occupancy count replaces the free-running add counter the issue stage uses for its structural-hazard check.

## Interface
Parameters:
- DEPTH, 3, number of station entries (2..8)
- DATA_W, 16, operand/result width
- TAG_W, 3, ROB index width
- FUNC_W, 4, opcode width

Ports:
- clk1  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (branch mispredict); synchronous
- iss_valid  in  1  issue stage presents an instruction
- iss_ready  out  1  station can accept (count < DEPTH)
- iss_func  in  FUNC_W  opcode, forwarded unmodified
- iss_rob  in  TAG_W  destination ROB index
- iss_q1_busy, iss_q2_busy  in  1  operand not yet available; the matching iss_v field holds a tag
- iss_v1, iss_v2  in  DATA_W  operand value, or ROB tag in [TAG_W-1:0] when busy
- cdb_valid  in  1  result broadcast this cycle
- cdb_tag  in  TAG_W  ROB index of broadcast result
- cdb_data  in  DATA_W  broadcast value
- ex_valid  out  1  an entry is ready to dispatch
- ex_ready  in  1  ALU accepts
- ex_func  out  FUNC_W, ex_a, ex_b  out  DATA_W, ex_rob  out  TAG_W  dispatched instruction
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is a collapsing queue: entry 0 is the oldest. Each entry holds valid, func, rob, and two operand cells (busy, tag, value).
- Allocate when iss_valid && iss_ready. The new entry is written at index count, or at count-1 if a dispatch occurs in the same cycle.
- Issue/CDB bypass: if an incoming operand is busy, cdb_valid is high and cdb_tag equals that operand's tag, the operand is stored non-busy with value cdb_data.
- Wakeup: every valid entry's busy operand whose tag matches cdb_tag while cdb_valid is high captures cdb_data and clears busy.
- Select: the lowest-index entry with valid and both operands non-busy drives ex_*. ex_valid is high when such an entry exists. Outputs are combinational from registered entry state.
- Dispatch happens when ex_valid && ex_ready. The selected entry is removed and the entries above it shift down by one, preserving age order.
- An operand woken at edge N becomes eligible for selection in the cycle after edge N; there is no same-cycle CDB-to-dispatch forwarding.
- iss_ready = (count < DEPTH), based on registered count only. When the station is full, a dispatch in the same cycle does not free a slot for that cycle's issue.
- count is incremented on allocate and decremented on dispatch; both in the same cycle leave it unchanged.

## Timing
- Reset or flush: all valid bits cleared, count=0, ex_valid=0, iss_ready=1, ex_func/ex_a/ex_b/ex_rob=0. Flush overrides allocate, wakeup and dispatch in the same cycle.
- Reset asserted mid-operation discards in-flight entries at the next edge. There is no partial state.
- Minimum latency: issue with both operands ready at edge N, ex_valid high after N, dispatch at edge N+1.
- Waiting operand: CDB match at edge M, ex_valid high after M (provided it is the oldest ready entry).
- ex_* must hold stable while ex_valid && !ex_ready, unless flush or rst is asserted. A newly ready older entry must not pre-empt a stalled presented entry: once presented, an entry stays selected until dispatched.
- Duplicate CDB tags across entries wake all matching entries in the same cycle.

## Structure
- tomasulo_pkg holds: DATA_W/TAG_W/FUNC_W constants, FUNC_ADD=4'b0000, FUNC_SUB=4'b0001, and an rs_entry_t struct (valid, func, rob, q1/q2 busy, tag, value).
- Sub-module rs_operand: one operand cell with load, bypass and CDB wakeup logic. It is instantiated 2×DEPTH times.
- Top level: allocation index, collapse/shift, sticky select, count.

## Test plan
- Reset, then issue add with v1=5, v2=7, both ready, rob=2, ex_ready=1 -> ex_valid one cycle later with ex_a=5, ex_b=7, ex_rob=2; count goes 1 then 0.
- Issue with q1_busy, tag=4; three cycles later cdb_valid with tag=4, data=0x00AA -> ex_a=0x00AA and ex_valid on the cycle after the broadcast, not before.
- Fill 3 entries with ex_ready=0 -> iss_ready=0 and count=3. A 4th iss_valid is ignored. Raising ex_ready dispatches in rob order 0,1,2.
- Issue busy tag=6 in the same cycle cdb_tag=6, data=9 -> entry stored ready, ex_a=9 next cycle.
- Entry 0 waiting, entry 1 ready -> entry 1 dispatches first. Entry 0 then wakes via CDB, dispatches, and count returns to 0.
- Flush with 2 entries while ex_valid=1 and ex_ready=0 -> next cycle count=0, ex_valid=0, and the CDB tag of a discarded entry causes no dispatch.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo-style reservation stations.
//   DATA_W / TAG_W / FUNC_W : default operand, ROB-tag and opcode widths
//   FUNC_ADD / FUNC_SUB     : add/sub functional-unit opcodes
//   rs_opnd_t / rs_entry_t  : architectural view of one station entry
//   first_set()             : index of the lowest set bit of a readiness mask
package tomasulo_pkg;

  localparam int DATA_W    = 16;
  localparam int TAG_W     = 3;
  localparam int FUNC_W    = 4;
  localparam int MAX_DEPTH = 8;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } rs_opnd_t;

  typedef struct packed {
    logic              valid;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  rob;
    rs_opnd_t          q1;
    rs_opnd_t          q2;
  } rs_entry_t;

  // Lowest set bit wins, so entry 0 (oldest) has priority.
  function automatic logic [2:0] first_set(input logic [MAX_DEPTH-1:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rs_operand.sv
// One source-operand cell of a reservation-station entry.
//   clk1, rst         : clock, synchronous active-high reset
//   clear_i           : flush, empties the cell
//   load_i, load_*    : write from the issue stage (value, or tag when busy)
//   shift_i, shift_*  : take the post-wakeup state of the entry above (collapse)
//   cdb_*             : result broadcast used for wakeup and issue bypass
//   busy_o, value_o   : registered state used for select/dispatch
//   nxt_*_o           : this cell after this cycle's wakeup, fed to the entry below
module rs_operand #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              load_busy_i,
  input  logic [DATA_W-1:0] load_v_i,
  input  logic              shift_i,
  input  logic              shift_busy_i,
  input  logic [TAG_W-1:0]  shift_tag_i,
  input  logic [DATA_W-1:0] shift_value_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] value_o,
  output logic              nxt_busy_o,
  output logic [TAG_W-1:0]  nxt_tag_o,
  output logic [DATA_W-1:0] nxt_value_o
);

  logic              busy_q, busy_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [TAG_W-1:0]  ld_tag;
  logic              ld_hit;

  assign ld_tag = load_v_i[TAG_W-1:0];
  assign ld_hit = cdb_valid_i && (cdb_tag_i == ld_tag);

  always_comb begin
    nxt_busy_o  = busy_q;
    nxt_tag_o   = tag_q;
    nxt_value_o = value_q;
    if (cdb_valid_i && busy_q && (tag_q == cdb_tag_i)) begin
      nxt_busy_o  = 1'b0;
      nxt_value_o = cdb_data_i;
    end
  end

  always_comb begin
    busy_d  = nxt_busy_o;
    tag_d   = nxt_tag_o;
    value_d = nxt_value_o;
    if (load_i) begin
      if (load_busy_i && !ld_hit) begin
        busy_d  = 1'b1;
        tag_d   = ld_tag;
        value_d = '0;
      end else if (load_busy_i) begin
        // result arrives on the CDB in the same cycle the operand is issued
        busy_d  = 1'b0;
        tag_d   = ld_tag;
        value_d = cdb_data_i;
      end else begin
        busy_d  = 1'b0;
        tag_d   = '0;
        value_d = load_v_i;
      end
    end else if (shift_i) begin
      busy_d  = shift_busy_i;
      tag_d   = shift_tag_i;
      value_d = shift_value_i;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst || clear_i) begin
      busy_q  <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign busy_o  = busy_q;
  assign value_o = value_q;

endmodule

// File: rtl/rs_alu_station.sv
// Reservation station for the add/sub unit: collapsing age-ordered queue
// with CDB wakeup and a sticky oldest-ready select toward the ALU.
//   clk1, rst, flush : clock, synchronous reset, mispredict flush
//   iss_*            : instruction from the issue stage, iss_ready back
//   cdb_*            : result broadcast
//   ex_*             : dispatch handshake toward the ALU
//   count            : occupied entries, used by issue for hazard checks
module rs_alu_station #(
  parameter int  DEPTH  = 3,
  parameter int  DATA_W = tomasulo_pkg::DATA_W,
  parameter int  TAG_W  = tomasulo_pkg::TAG_W,
  parameter int  FUNC_W = tomasulo_pkg::FUNC_W,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [FUNC_W-1:0] iss_func,
  input  logic [TAG_W-1:0]  iss_rob,
  input  logic              iss_q1_busy,
  input  logic              iss_q2_busy,
  input  logic [DATA_W-1:0] iss_v1,
  input  logic [DATA_W-1:0] iss_v2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [FUNC_W-1:0] ex_func,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [TAG_W-1:0]  ex_rob,
  output logic [CNT_W-1:0]  count
);
  import tomasulo_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [FUNC_W-1:0] func_q [DEPTH];
  logic [FUNC_W-1:0] func_d [DEPTH];
  logic [TAG_W-1:0]  rob_q  [DEPTH];
  logic [TAG_W-1:0]  rob_d  [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pres_q, pres_d;
  logic [IDX_W-1:0]  pres_idx_q, pres_idx_d;

  // Operand cell state; the extra top element is the empty slot above the queue.
  logic              q1_busy [DEPTH];
  logic              q2_busy [DEPTH];
  logic [DATA_W-1:0] q1_val  [DEPTH];
  logic [DATA_W-1:0] q2_val  [DEPTH];
  logic              q1_nbusy[DEPTH+1];
  logic              q2_nbusy[DEPTH+1];
  logic [TAG_W-1:0]  q1_ntag [DEPTH+1];
  logic [TAG_W-1:0]  q2_ntag [DEPTH+1];
  logic [DATA_W-1:0] q1_nval [DEPTH+1];
  logic [DATA_W-1:0] q2_nval [DEPTH+1];

  logic [DEPTH:0]         valid_up;
  logic [FUNC_W-1:0]      func_up[DEPTH+1];
  logic [TAG_W-1:0]       rob_up [DEPTH+1];
  logic [MAX_DEPTH-1:0]   rdy_pad;
  logic                   any_rdy;
  logic [IDX_W-1:0]       sel_idx;
  logic                   dispatch, alloc;
  logic [CNT_W-1:0]       alloc_idx;
  logic [DEPTH-1:0]       ld_en, sh_en;

  assign q1_nbusy[DEPTH] = 1'b0;
  assign q2_nbusy[DEPTH] = 1'b0;
  assign q1_ntag[DEPTH]  = '0;
  assign q2_ntag[DEPTH]  = '0;
  assign q1_nval[DEPTH]  = '0;
  assign q2_nval[DEPTH]  = '0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_q1 (
      .clk1         (clk1),
      .rst          (rst),
      .clear_i      (flush),
      .load_i       (ld_en[g]),
      .load_busy_i  (iss_q1_busy),
      .load_v_i     (iss_v1),
      .shift_i      (sh_en[g]),
      .shift_busy_i (q1_nbusy[g+1]),
      .shift_tag_i  (q1_ntag[g+1]),
      .shift_value_i(q1_nval[g+1]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_data_i   (cdb_data),
      .busy_o       (q1_busy[g]),
      .value_o      (q1_val[g]),
      .nxt_busy_o   (q1_nbusy[g]),
      .nxt_tag_o    (q1_ntag[g]),
      .nxt_value_o  (q1_nval[g])
    );
    rs_operand #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_q2 (
      .clk1         (clk1),
      .rst          (rst),
      .clear_i      (flush),
      .load_i       (ld_en[g]),
      .load_busy_i  (iss_q2_busy),
      .load_v_i     (iss_v2),
      .shift_i      (sh_en[g]),
      .shift_busy_i (q2_nbusy[g+1]),
      .shift_tag_i  (q2_ntag[g+1]),
      .shift_value_i(q2_nval[g+1]),
      .cdb_valid_i  (cdb_valid),
      .cdb_tag_i    (cdb_tag),
      .cdb_data_i   (cdb_data),
      .busy_o       (q2_busy[g]),
      .value_o      (q2_val[g]),
      .nxt_busy_o   (q2_nbusy[g]),
      .nxt_tag_o    (q2_ntag[g]),
      .nxt_value_o  (q2_nval[g])
    );
  end

  // Select: a presented-but-stalled entry keeps the slot until it leaves,
  // otherwise the oldest entry with both operands available.
  always_comb begin
    rdy_pad = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_pad[i] = valid_q[i] & ~q1_busy[i] & ~q2_busy[i];
    end
  end

  assign any_rdy   = |rdy_pad;
  assign sel_idx   = pres_q ? pres_idx_q : IDX_W'(first_set(rdy_pad));
  assign ex_valid  = pres_q | any_rdy;
  assign iss_ready = (count_q < CNT_W'(DEPTH));
  assign count     = count_q;

  always_comb begin
    ex_func = '0;
    ex_a    = '0;
    ex_b    = '0;
    ex_rob  = '0;
    if (ex_valid) begin
      ex_func = func_q[sel_idx];
      ex_a    = q1_val[sel_idx];
      ex_b    = q2_val[sel_idx];
      ex_rob  = rob_q[sel_idx];
    end
  end

  always_comb begin
    valid_up = {1'b0, valid_q};
    for (int i = 0; i < DEPTH; i++) begin
      func_up[i] = func_q[i];
      rob_up[i]  = rob_q[i];
    end
    func_up[DEPTH] = '0;
    rob_up[DEPTH]  = '0;
  end

  always_comb begin
    dispatch  = ex_valid & ex_ready;
    alloc     = iss_valid & iss_ready;
    // a same-cycle dispatch collapses the queue, so the free slot moves down
    alloc_idx = dispatch ? (count_q - CNT_W'(1)) : count_q;
    for (int i = 0; i < DEPTH; i++) begin
      ld_en[i]   = alloc && (alloc_idx == CNT_W'(i));
      sh_en[i]   = dispatch && (i >= int'(sel_idx));
      valid_d[i] = valid_q[i];
      func_d[i]  = func_q[i];
      rob_d[i]   = rob_q[i];
      if (ld_en[i]) begin
        valid_d[i] = 1'b1;
        func_d[i]  = iss_func;
        rob_d[i]   = iss_rob;
      end else if (sh_en[i]) begin
        valid_d[i] = valid_up[i+1];
        func_d[i]  = func_up[i+1];
        rob_d[i]   = rob_up[i+1];
      end
    end

    count_d = count_q;
    if (alloc && !dispatch)      count_d = count_q + CNT_W'(1);
    else if (!alloc && dispatch) count_d = count_q - CNT_W'(1);

    pres_d     = ex_valid && !ex_ready;
    pres_idx_d = sel_idx;
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      valid_q    <= '0;
      count_q    <= '0;
      pres_q     <= 1'b0;
      pres_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        func_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      pres_q     <= pres_d;
      pres_idx_q <= pres_idx_d;
      for (int i = 0; i < DEPTH; i++) begin
        func_q[i] <= func_d[i];
        rob_q[i]  <= rob_d[i];
      end
    end
  end

endmodule
